// File: rtl/rr_channel_arbiter.sv
// rtl/rr_channel_arbiter.sv - round-robin arbiter sharing one 4-phase bundled-data channel
// Optional per-requester grant counters on output stat_grants when ARB_STAT_EN is defined.
module rr_channel_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       in_req,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]       in_ack,
    output logic                     out_req,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ack,
    output logic [SEL_W-1:0]         out_sel
`ifdef ARB_STAT_EN
    ,
    output logic [NUM_REQ*16-1:0]    stat_grants
`endif
);

    typedef enum logic [1:0] {IDLE, SEND, RTZ} state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [SEL_W-1:0]   win;
    logic [SEL_W:0]     sum;
    logic [WIDTH-1:0]   win_data;
    logic               req_n;
    logic [NUM_REQ-1:0] ack_n;
    logic [WIDTH-1:0]   data_n;
    logic [SEL_W-1:0]   sel_n;
    logic               grant_done;

    // Scan from the farthest candidate back to ptr so the closest set bit wins.
    always_comb begin
        win = ptr;
        sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(NUM_REQ))
                sum = sum - (SEL_W + 1)'(NUM_REQ);
            if (in_req[sum[SEL_W-1:0]])
                win = sum[SEL_W-1:0];
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SEL_W'(i) == win)
                win_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        req_n      = out_req;
        ack_n      = in_ack;
        data_n     = out_data;
        sel_n      = out_sel;
        grant_done = 1'b0;
        case (state)
            IDLE: begin
                if (|in_req) begin
                    data_n  = win_data;
                    sel_n   = win;
                    req_n   = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_ack) begin
                    req_n      = 1'b0;
                    ack_n      = {{(NUM_REQ-1){1'b0}}, 1'b1} << out_sel;
                    grant_done = 1'b1;
                    state_n    = RTZ;
                end
            end
            RTZ: begin
                if (!in_req[out_sel] && !out_ack) begin
                    ack_n   = '0;
                    ptr_n   = (out_sel == SEL_W'(NUM_REQ - 1)) ? '0 : out_sel + 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
                ack_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            out_req  <= 1'b0;
            out_data <= '0;
            out_sel  <= '0;
            in_ack   <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            out_req  <= req_n;
            out_data <= data_n;
            out_sel  <= sel_n;
            in_ack   <= ack_n;
        end
    end

`ifdef ARB_STAT_EN
    logic [15:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++)
                grant_cnt[i] <= '0;
        end else if (grant_done && grant_cnt[out_sel] != 16'hFFFF) begin
            grant_cnt[out_sel] <= grant_cnt[out_sel] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_grants[gi*16 +: 16] = grant_cnt[gi];
    end
`endif

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// tb/tb_rr_channel_arbiter.sv - randomized transaction-level check of rr_channel_arbiter
module tb_rr_channel_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_req;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ack;
    logic           out_req;
    logic [W-1:0]   out_data;
    logic           out_ack;
    logic [SW-1:0]  out_sel;
`ifdef ARB_STAT_EN
    logic [N*16-1:0] stat_grants;
`endif

    rr_channel_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_req(in_req), .in_data(in_data),
        .in_ack(in_ack), .out_req(out_req), .out_data(out_data),
        .out_ack(out_ack), .out_sel(out_sel)
`ifdef ARB_STAT_EN
        , .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         ptr_m = 0;
    logic [W-1:0] dat [N];
    int         grants_m [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner = first requester at or after the pointer, wrapping around.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            int idx = (p + k) % N;
            if (((m >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    task automatic pack_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
    endtask

    // Called at a negedge; returns at a negedge with the arbiter back in idle.
    task automatic xfer(input logic [N-1:0] mask, input int ack_dly, input int rtz_dly, input bit rnd);
        int w;
        logic [N-1:0] oh;
        if (rnd) for (int i = 0; i < N; i++) dat[i] = W'($urandom);
        pack_data();
        in_req  = mask;
        out_ack = 1'b0;
        w  = pick(mask, ptr_m);
        oh = 4'd1 << w;
        @(negedge clk);
        check("out_req_rise", {31'd0, out_req}, 32'd1);
        check("out_sel", {30'd0, out_sel}, w);
        check("out_data", {24'd0, out_data}, {24'd0, dat[w]});
        check("in_ack_send", {28'd0, in_ack}, 32'd0);
        for (int d = 0; d < ack_dly; d++) begin
            in_req = (4'($urandom) & ~oh) | oh;
            for (int i = 0; i < N; i++) if (i != w) dat[i] = W'($urandom);
            pack_data();
            @(negedge clk);
            check("stall_req", {31'd0, out_req}, 32'd1);
            check("stall_data", {24'd0, out_data}, {24'd0, dat[w]});
            check("stall_ack", {28'd0, in_ack}, 32'd0);
        end
        out_ack = 1'b1;
        @(negedge clk);
        check("ack_req_low", {31'd0, out_req}, 32'd0);
        check("in_ack_high", {28'd0, in_ack}, {28'd0, oh});
        grants_m[w]++;
        for (int r = 0; r < rtz_dly; r++) begin
            case ($urandom_range(0, 2))
                0: begin in_req = (4'($urandom) & ~oh) | oh; out_ack = 1'b0; end
                1: begin in_req = 4'($urandom) & ~oh; out_ack = 1'b1; end
                default: begin in_req = 4'($urandom) | oh; out_ack = 1'b1; end
            endcase
            @(negedge clk);
            check("rtz_ack", {28'd0, in_ack}, {28'd0, oh});
            check("rtz_req", {31'd0, out_req}, 32'd0);
        end
        in_req  = in_req & ~oh;
        out_ack = 1'b0;
        @(negedge clk);
        check("rtz_exit_ack", {28'd0, in_ack}, 32'd0);
        check("rtz_exit_req", {31'd0, out_req}, 32'd0);
        check("sel_hold", {30'd0, out_sel}, w);
        ptr_m  = (w + 1) % N;
        in_req = '0;
    endtask

    initial begin
        reset   = 1'b1;
        in_req  = '0;
        in_data = '0;
        out_ack = 1'b0;
        for (int i = 0; i < N; i++) begin dat[i] = '0; grants_m[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_out_req", {31'd0, out_req}, 32'd0);
        check("rst_in_ack", {28'd0, in_ack}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_sel", {30'd0, out_sel}, 32'd0);
`ifdef ARB_STAT_EN
        check("rst_stat", stat_grants[31:0], 32'd0);
`endif
        reset = 1'b0;

        // All four requesting: data 10..13, grants 0,1,2,3,0.
        for (int i = 0; i < N; i++) dat[i] = W'(8'h10 + i);
        for (int t = 0; t < 5; t++) begin
            xfer(4'b1111, 0, 0, 1'b0);
            check("rr_order", ptr_m, (t + 1) % N);
        end

        // Single requester 2 with A5.
        dat[2] = 8'hA5;
        xfer(4'b0100, 1, 1, 1'b0);
        check("ptr_after_2", ptr_m, 3);

        // Serve 3, then 0 beats 3.
        xfer(4'b1000, 0, 0, 1'b1);
        xfer(4'b1001, 0, 0, 1'b1);
        check("fair_0_first", ptr_m, 1);

        // Stalled consumer for 20 cycles.
        xfer(4'b0010, 20, 0, 1'b1);

        // out_ack in idle is ignored.
        out_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_ignored", {31'd0, out_req}, 32'd0);
        out_ack = 1'b0;

        // Reset during RTZ with in_ack[1] high.
        in_req = 4'b0010;
        @(negedge clk);
        out_ack = 1'b1;
        @(negedge clk);
        check("pre_rst_ack", {28'd0, in_ack}, 32'h2);
        #2 reset = 1'b1;
        #1;
        check("async_in_ack", {28'd0, in_ack}, 32'd0);
        check("async_out_req", {31'd0, out_req}, 32'd0);
        check("async_out_sel", {30'd0, out_sel}, 32'd0);
        ptr_m = 0;
        for (int i = 0; i < N; i++) grants_m[i] = 0;
        out_ack = 1'b0;
        in_req  = '0;
        @(negedge clk);
        reset = 1'b0;
        xfer(4'b0010, 0, 0, 1'b1);
        xfer(4'b1111, 0, 0, 1'b1);
        check("post_rst_ptr", ptr_m, 3);

        for (int t = 0; t < 200; t++) begin
            xfer(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                out_ack = 1'b1;
                @(negedge clk);
                check("rnd_idle_ack", {31'd0, out_req}, 32'd0);
                out_ack = 1'b0;
            end
        end

`ifdef ARB_STAT_EN
        for (int i = 0; i < N; i++)
            check("stat_count", {16'd0, stat_grants[i*16 +: 16]}, grants_m[i]);
        for (int t = 0; t < 70000; t++) begin
            in_req = 4'b0001;
            @(negedge clk);
            out_ack = 1'b1;
            @(negedge clk);
            in_req  = '0;
            out_ack = 1'b0;
            @(negedge clk);
        end
        check("stat_sat", {16'd0, stat_grants[15:0]}, 32'hFFFF);
        for (int i = 1; i < N; i++)
            check("stat_other", {16'd0, stat_grants[i*16 +: 16]}, grants_m[i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rr_channel_arbiter.md
Name: rr_channel_arbiter

Overview:
- Clocked round-robin arbiter that shares one outgoing 4-phase bundled-data channel between NUM_REQ requesting channels.
- Sits in front of a shared consumer, such as a single full buffer or adder input fed by several generators. It serialises requests, so exactly one requester's token is in flight at any time.
- All handshake inputs are synchronous to clk; any synchronisers are external.

Parameters:
- NUM_REQ, 4, number of requester channels (2..16).
- WIDTH, 8, data width per channel.
- SEL_W, $clog2(NUM_REQ), width of grant index (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_req  input  NUM_REQ  per-requester 4-phase request.
- in_data  input  NUM_REQ*WIDTH  requester data; slice i = bits [i*WIDTH +: WIDTH]; stable while in_req[i]=1.
- in_ack  output  NUM_REQ  per-requester 4-phase acknowledge.
- out_req  output  1  shared channel request.
- out_data  output  WIDTH  shared channel data, valid while out_req=1.
- out_ack  input  1  shared channel acknowledge.
- out_sel  output  SEL_W  index of the current/last granted requester.

Behaviour:
- All outputs are registered. Reset values: in_ack=0, out_req=0, out_data=0, out_sel=0, round-robin pointer ptr=0, state=IDLE.
- IDLE:
  - If in_req != 0, choose winner g = first set bit searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - Latch out_data <= in_data[g], out_sel <= g, out_req <= 1, then go to SEND.
  - Latency: in_req sampled at edge k gives out_req=1 after edge k.
- SEND: hold out_req=1 and out_data. When out_ack=1 is sampled: out_req <= 0, in_ack[g] <= 1, go to RTZ.
- RTZ (return-to-zero): when in_req[g]=0 and out_ack=0 are sampled together: in_ack[g] <= 0, ptr <= (g+1) mod NUM_REQ, go to IDLE.
- A minimum full transfer takes 3 cycles: IDLE, SEND, RTZ. A new grant is issued in the IDLE cycle after RTZ; there is no back-to-back grant out of RTZ.
- Fairness: the requester just served has lowest priority next time. With all requesters asserted, grant order is 0,1,2,...,NUM_REQ-1,0,...
- Only in_ack[g] can be high at any time; all other in_ack bits stay 0.
- Requests other than g that rise or fall during SEND or RTZ are ignored until IDLE.
- Protocol violation handling:
  - in_req[g] dropping during SEND: the transfer completes with the latched data.
  - out_ack=1 while in IDLE: ignored.
- out_data and out_sel hold their last values outside SEND.
- Reset asserted mid-transfer: all outputs are cleared immediately (asynchronously). The in-flight token is abandoned and ptr returns to 0.
- NUM_REQ not a power of 2: wrap is explicit modulo NUM_REQ; SEL_W values >= NUM_REQ never appear.

Optional Feature:
- Macro ARB_STAT_EN.
- Defined:
  - Adds output stat_grants (NUM_REQ*16 bits): one 16-bit grant counter per requester, slice i = bits [i*16 +: 16].
  - The counter increments on the SEND->RTZ transition for g and saturates at 16'hFFFF. Reset clears all counters to 0.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: in_req=4'b0100, in_data[2]=8'hA5, out_ack returned 1 cycle after out_req -> out_req rises 1 cycle after in_req, out_data=8'hA5, out_sel=2, in_ack=4'b0100 until in_req[2] drops; ptr becomes 3.
- All four requesting continuously with data 8'h10..8'h13 -> out_data sequence 10,11,12,13,10; each transfer takes 3 cycles with immediate acks.
- Fairness after pointer move: serve requester 3, then in_req=4'b1001 -> grant 0 before 3.
- Stalled consumer: out_ack held 0 for 20 cycles -> out_req stays 1 and out_data stays stable; no in_ack toggles. Other requesters rising meanwhile are not granted until RTZ->IDLE.
- Reset during RTZ with in_ack[1]=1 -> in_ack=0, out_req=0, out_sel=0 at once. After release with in_req=4'b0010, grant goes to 1 again with ptr starting at 0.
- ARB_STAT_EN: 70000 grants to requester 0 -> stat_grants[15:0]=16'hFFFF, saturated; other slices remain 0.
